// File: rtl/alu_seq_pkg.sv
// alu_sequencer shared types and defaults.
// State encoding, default widths and timer sizing.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } seq_state_e;

  localparam int BUS_W_DEF   = 16;
  localparam int OP_W_DEF    = 6;
  localparam int TIMEOUT_DEF = 1000;

  function automatic int tmr_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int TMR_W_DEF = tmr_w(TIMEOUT_DEF);

endpackage

// File: rtl/alu_sequencer_timer.sv
// Idle down-counter for partial transactions.
// Expire is asserted on the CYCLES-th idle edge after a load.
module seq_timer
  import alu_seq_pkg::*;
#(
  parameter int CYCLES = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int W = tmr_w(CYCLES);
  localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = run_i && !load_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = RELOAD;
    else if (run_i && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Stream-fed ALU operand sequencer.
// Collects A, B, opcode words and returns the ALU result.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int BUS_WIDTH      = BUS_W_DEF,
  parameter int OP_WIDTH       = OP_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic [BUS_WIDTH-1:0] i_data,
  output logic                 o_ready,
  output logic [BUS_WIDTH-1:0] o_alu_a,
  output logic [BUS_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]  o_alu_op,
  input  logic [BUS_WIDTH-1:0] i_alu_result,
  output logic                 o_res_valid,
  output logic [BUS_WIDTH-1:0] o_res_data,
  input  logic                 i_res_ready,
  output logic                 o_timeout,
  output logic [CNT_WIDTH-1:0] o_op_count
);

  seq_state_e           state_q;
  logic [BUS_WIDTH-1:0] a_q, b_q, res_q;
  logic [OP_WIDTH-1:0]  op_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 tmo_q;
  logic                 xfer, run, expire;

  assign o_ready = (state_q == GET_A) ||
                   (state_q == GET_B) ||
                   (state_q == GET_OP);
  assign o_res_valid = (state_q == SEND);
  assign xfer = i_valid && o_ready;
  assign run  = (state_q == GET_B) || (state_q == GET_OP);

  // Every transfer reloads, which also covers entry to GET_B.
  seq_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run_i   (run),
    .load_i  (xfer),
    .expire_o(expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state_q)
        GET_A: begin
          if (xfer) begin
            a_q     <= i_data;
            state_q <= GET_B;
          end
        end
        GET_B: begin
          if (xfer) begin
            b_q     <= i_data;
            state_q <= GET_OP;
          end else if (expire) begin
            tmo_q   <= 1'b1;
            state_q <= GET_A;
          end
        end
        GET_OP: begin
          if (xfer) begin
            op_q    <= i_data[OP_WIDTH-1:0];
            state_q <= EXEC;
          end else if (expire) begin
            tmo_q   <= 1'b1;
            state_q <= GET_A;
          end
        end
        EXEC: begin
          res_q   <= i_alu_result;
          state_q <= SEND;
        end
        SEND: begin
          if (i_res_ready) begin
            cnt_q   <= cnt_q + CNT_WIDTH'(1);
            state_q <= GET_A;
          end
        end
        default: state_q <= GET_A;
      endcase
    end
  end

  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_alu_op   = op_q;
  assign o_res_data = res_q;
  assign o_op_count = cnt_q;
  assign o_timeout  = tmo_q;

endmodule
